clk_div_prog: RTL and testbench

Parametrised successor to the fixed CPU clock divider. Derives NUM_CH independent divided clocks from the 100 MHz system clock, with a matching one-cycle enable strobe for each. Each channel's divisor is runtime-programmable and glitch-free: a new divisor takes effect only at a period boundary, which is how CGB double-speed switching is done. A global sync re-aligns the phase of all channels; a global enable freezes them. Channel 0 is the CPU clock; the other channels feed the APU, timer and serial blocks.

---
 rtl/clk_div_pkg.sv | 9 +
 rtl/clk_div_chan.sv | 99 +++++++++
 rtl/clk_div_prog.sv | 38 +++
 tb/tb_clk_div_prog.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants for the programmable clock divider.
package clk_div_pkg;

   localparam int unsigned CNT_W_DEF     = 8;
   localparam int unsigned DIV_MIN       = 2;
   localparam int unsigned DIV_GB_NORMAL = 24;
   localparam int unsigned DIV_GB_DOUBLE = 12;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active/pending divisor and the registered
// clk_out / clk_en / div_ack outputs.
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int unsigned CNT_W     = CNT_W_DEF,
   parameter int unsigned DIV_RESET = DIV_GB_NORMAL
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_enable,
   input  logic             i_sync,
   input  logic [CNT_W-1:0] i_div_val,
   input  logic             i_div_load,
   output logic             o_div_ack,
   output logic             o_clk_out,
   output logic             o_clk_en
);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_div_cur;
   logic [CNT_W-1:0] r_pend;
   logic             r_pend_vld;
   logic             r_clk_out;
   logic             r_clk_en;
   logic             r_div_ack;

   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_div_nxt;
   logic [CNT_W-1:0] w_pend_nxt;
   logic [CNT_W-1:0] w_load_val;
   logic             w_pend_vld_nxt;
   logic             w_out_nxt;
   logic             w_en_nxt;
   logic             w_ack_nxt;
   logic             w_wrap;
   logic             w_bound;

   // Next-state: a pending divisor is only promoted at a period boundary (wrap or sync).
   always_comb begin
      w_cnt_nxt      = r_cnt;
      w_div_nxt      = r_div_cur;
      w_pend_nxt     = r_pend;
      w_pend_vld_nxt = r_pend_vld;
      w_out_nxt      = r_clk_out;
      w_en_nxt       = 1'b0;
      w_ack_nxt      = 1'b0;
      w_load_val     = (i_div_val < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : i_div_val;
      w_wrap         = (r_cnt == (r_div_cur - CNT_W'(1)));
      w_bound        = i_sync | (i_enable & w_wrap);

      if (w_bound && r_pend_vld) begin
         w_div_nxt      = r_pend;
         w_pend_vld_nxt = 1'b0;
         w_ack_nxt      = 1'b1;
      end

      // A load coinciding with a boundary becomes pending for the next one.
      if (i_div_load) begin
         w_pend_nxt     = w_load_val;
         w_pend_vld_nxt = 1'b1;
      end

      if (i_sync) begin
         w_cnt_nxt = '0;
         w_out_nxt = 1'b1;
         w_en_nxt  = i_enable;
      end else if (i_enable) begin
         w_cnt_nxt = w_wrap ? '0 : (r_cnt + CNT_W'(1));
         w_out_nxt = (w_cnt_nxt < (w_div_nxt >> 1));
         w_en_nxt  = (w_cnt_nxt == '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_div_cur  <= CNT_W'(DIV_RESET);
         r_pend     <= CNT_W'(DIV_MIN);
         r_pend_vld <= 1'b0;
         r_clk_out  <= 1'b0;
         r_clk_en   <= 1'b0;
         r_div_ack  <= 1'b0;
      end else begin
         r_cnt      <= w_cnt_nxt;
         r_div_cur  <= w_div_nxt;
         r_pend     <= w_pend_nxt;
         r_pend_vld <= w_pend_vld_nxt;
         r_clk_out  <= w_out_nxt;
         r_clk_en   <= w_en_nxt;
         r_div_ack  <= w_ack_nxt;
      end
   end

   assign o_div_ack = r_div_ack;
   assign o_clk_out = r_clk_out;
   assign o_clk_en  = r_clk_en;

endmodule

// File: rtl/clk_div_prog.sv
// NUM_CH independent programmable clock dividers sharing enable, sync and reset.
// Channel 0 is the CPU clock; the rest feed APU, timer and serial.
module clk_div_prog
   import clk_div_pkg::*;
#(
   parameter int unsigned NUM_CH    = 2,
   parameter int unsigned CNT_W     = CNT_W_DEF,
   parameter int unsigned DIV_RESET = DIV_GB_NORMAL
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    sync,
   input  logic [NUM_CH*CNT_W-1:0] div_val,
   input  logic [NUM_CH-1:0]       div_load,
   output logic [NUM_CH-1:0]       div_ack,
   output logic [NUM_CH-1:0]       clk_out,
   output logic [NUM_CH-1:0]       clk_en
);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clk_div_chan #(
         .CNT_W     (CNT_W),
         .DIV_RESET (DIV_RESET)
      ) u_chan (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_enable   (enable),
         .i_sync     (sync),
         .i_div_val  (div_val[g*CNT_W +: CNT_W]),
         .i_div_load (div_load[g]),
         .o_div_ack  (div_ack[g]),
         .o_clk_out  (clk_out[g]),
         .o_clk_en   (clk_en[g])
      );
   end

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: stimulus pushes expected clk_out levels and
// clk_en/div_ack pulses keyed by cycle; a negedge monitor matches them.
module tb_clk_div_prog;

   localparam int NUM_CH = 2;
   localparam int CNT_W  = 8;
   localparam int K_EN   = 0;
   localparam int K_ACK  = 1;
   localparam int K_OUT  = 2;

   typedef struct {
      int   ch;
      int   kind;
      int   cyc;
      logic val;
   } exp_t;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic                    enable;
   logic                    sync;
   logic [NUM_CH*CNT_W-1:0] div_val;
   logic [NUM_CH-1:0]       div_load;
   logic [NUM_CH-1:0]       div_ack;
   logic [NUM_CH-1:0]       clk_out;
   logic [NUM_CH-1:0]       clk_en;

   exp_t sb[$];
   int   cyc     = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   clk_div_prog #(
      .NUM_CH    (NUM_CH),
      .CNT_W     (CNT_W),
      .DIV_RESET (24)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .sync     (sync),
      .div_val  (div_val),
      .div_load (div_load),
      .div_ack  (div_ack),
      .clk_out  (clk_out),
      .clk_en   (clk_en)
   );

   always #5 clk = ~clk;

   // Edge index since the last reset release: edge 1 is the first counting edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   function automatic int find(input int ch, input int kind, input int c);
      for (int i = 0; i < sb.size(); i++)
         if (sb[i].ch == ch && sb[i].kind == kind && sb[i].cyc == c) return i;
      return -1;
   endfunction

   task automatic push(input int ch, input int kind, input int c, input logic v);
      exp_t e;
      e.ch = ch; e.kind = kind; e.cyc = c; e.val = v;
      sb.push_back(e);
   endtask

   // Expected clk_out over len cycles, cnt0 being the counter value at cycle c0.
   task automatic exp_wave(input int ch, input int c0, input int cnt0, input int n,
                           input int hi, input int len);
      for (int k = 0; k < len; k++) push(ch, K_OUT, c0 + k, ((cnt0 + k) % n) < hi);
   endtask

   task automatic exp_const(input int ch, input int c0, input int len, input logic v);
      for (int k = 0; k < len; k++) push(ch, K_OUT, c0 + k, v);
   endtask

   task automatic exp_pulses(input int ch, input int kind, input int c0, input int per,
                             input int cnt);
      for (int k = 0; k < cnt; k++) push(ch, kind, c0 + k * per, 1'b1);
   endtask

   task automatic check_pulse(input int ch, input int kind, input logic act, input string nm);
      int idx;
      idx = find(ch, kind, cyc);
      if (idx >= 0 || act === 1'b1) begin
         n_checks++;
         if (idx < 0) begin
            n_fail++;
            $display("FAIL %s[%0d] cyc %0d: got pulse, want none", nm, ch, cyc);
         end else begin
            if (act !== 1'b1) begin
               n_fail++;
               $display("FAIL %s[%0d] cyc %0d: got %b, want pulse", nm, ch, cyc, act);
            end
            sb.delete(idx);
         end
      end
   endtask

   // Monitor: sample away from the active edge and retire matching expectations.
   always @(negedge clk) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
         int idx;
         idx = find(ch, K_OUT, cyc);
         if (idx >= 0) begin
            n_checks++;
            if (clk_out[ch] !== sb[idx].val) begin
               n_fail++;
               $display("FAIL clk_out[%0d] cyc %0d: got %b, want %b",
                        ch, cyc, clk_out[ch], sb[idx].val);
            end
            sb.delete(idx);
         end
         check_pulse(ch, K_EN,  clk_en[ch],  "clk_en");
         check_pulse(ch, K_ACK, div_ack[ch], "div_ack");
      end
   end

   task automatic at_cyc(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_load(input int c, input logic [1:0] mask, input logic [7:0] v0,
                          input logic [7:0] v1);
      at_cyc(c);
      div_val  = {v1, v0};
      div_load = mask;
      at_cyc(c + 1);
      div_load = '0;
   endtask

   task automatic check_zero(input string tag);
      n_checks++;
      if (clk_out !== 2'b00) begin
         n_fail++; $display("FAIL %s clk_out: got %b, want 00", tag, clk_out);
      end
      n_checks++;
      if (clk_en !== 2'b00) begin
         n_fail++; $display("FAIL %s clk_en: got %b, want 00", tag, clk_en);
      end
      n_checks++;
      if (div_ack !== 2'b00) begin
         n_fail++; $display("FAIL %s div_ack: got %b, want 00", tag, div_ack);
      end
   endtask

   initial begin
      #50000;
      $display("FAIL timeout: got no finish by 50 us, want finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n    = 1'b1;
      enable   = 1'b1;
      sync     = 1'b0;
      div_val  = '0;
      div_load = '0;
      #2 rst_n = 1'b0;

      // Reset divisor 24 on both channels
      exp_wave(0, 1, 1, 24, 12, 95);
      exp_wave(1, 1, 1, 24, 12, 119);
      exp_pulses(0, K_EN, 24, 24, 3);
      exp_pulses(1, K_EN, 24, 24, 4);
      #48 check_zero("reset");
      #52 rst_n = 1'b1;

      // Double-speed switch on ch0, loaded at cnt=5
      exp_wave(0, 96, 0, 12, 6, 39);
      exp_pulses(0, K_EN, 96, 12, 4);
      push(0, K_ACK, 96, 1'b1);
      do_load(77, 2'b01, 8'd12, 8'd0);

      // Clamp (1 -> 2) then odd divisor 5 loaded on a wrap edge
      exp_wave(1, 120, 0, 2, 1, 8);
      exp_wave(1, 128, 0, 5, 2, 10);
      exp_pulses(1, K_EN, 120, 2, 5);
      push(1, K_EN, 133, 1'b1);
      push(1, K_ACK, 120, 1'b1);
      push(1, K_ACK, 128, 1'b1);
      do_load(100, 2'b10, 8'd0, 8'd1);
      do_load(125, 2'b10, 8'd0, 8'd5);

      // ch0=24, ch1=7, then pending 9 on ch1 collides with sync
      exp_wave(0, 135, 3, 12, 6, 9);
      exp_wave(0, 144, 0, 24, 12, 19);
      exp_wave(0, 163, 0, 24, 12, 4);
      push(0, K_EN, 144, 1'b1);
      push(0, K_EN, 163, 1'b1);
      push(0, K_ACK, 144, 1'b1);
      exp_wave(1, 138, 0, 7, 3, 25);
      exp_wave(1, 163, 0, 9, 4, 4);
      exp_pulses(1, K_EN, 138, 7, 4);
      push(1, K_EN, 163, 1'b1);
      push(1, K_ACK, 138, 1'b1);
      push(1, K_ACK, 163, 1'b1);
      do_load(134, 2'b11, 8'd24, 8'd7);
      do_load(160, 2'b10, 8'd0, 8'd9);
      at_cyc(162);
      sync = 1'b1;
      at_cyc(163);
      sync = 1'b0;

      // Enable freeze for 10 edges at cnt=3
      at_cyc(166);
      exp_const(0, 167, 10, 1'b1);
      exp_wave(0, 177, 4, 24, 12, 29);
      push(0, K_EN, 197, 1'b1);
      exp_const(1, 167, 10, 1'b1);
      exp_wave(1, 177, 4, 9, 4, 29);
      exp_pulses(1, K_EN, 182, 9, 3);
      enable = 1'b0;
      at_cyc(176);
      enable = 1'b1;

      // Reset mid-period with a pending load on ch0
      do_load(200, 2'b01, 8'd12, 8'd0);
      at_cyc(205);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1 check_zero("async reset");
      exp_wave(0, 1, 1, 24, 12, 52);
      exp_wave(1, 1, 1, 24, 12, 52);
      exp_pulses(0, K_EN, 24, 24, 2);
      exp_pulses(1, K_EN, 24, 24, 2);
      #98 rst_n = 1'b1;
      at_cyc(52);
      @(negedge clk);
      #1;

      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL leftover: got %0d unmatched expectations (first ch%0d kind%0d cyc%0d), want 0",
                  sb.size(), sb[0].ch, sb[0].kind, sb[0].cyc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
